// File: rtl/trap_dump_if.sv
// trap_dump_if
//   Groups the DMEM read port and the dump stream port of the trap dump unit.
//   The DMEM word is big-endian, so the buses are numbered [0:31] with bit 0 as the MSB.
//   Signals:
//     mem_req     - DMEM word read strobe (unit -> memory)
//     mem_addr    - DMEM byte address of the word being read
//     mem_rdata   - DMEM word, valid exactly one cycle after mem_req
//     dump_valid  - dump_addr/dump_data hold a word for the consumer
//     dump_ready  - the consumer accepts the current word
//     dump_addr   - byte address of the word presented
//     dump_data   - word presented
//   Modports: master = dump unit side, slave = memory/consumer side.
interface trap_dump_if;
    logic        mem_req;
    logic [0:31] mem_addr;
    logic [0:31] mem_rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic [0:31] dump_addr;
    logic [0:31] dump_data;

    modport master (
        output mem_req, mem_addr, dump_valid, dump_addr, dump_data,
        input  mem_rdata, dump_ready
    );

    modport slave (
        input  mem_req, mem_addr, dump_valid, dump_addr, dump_data,
        output mem_rdata, dump_ready
    );
endinterface

// File: rtl/trap_dump_unit.sv
// trap_dump_unit
//   End-of-program dump engine for the 5-stage pipeline. When the decode-stage
//   instruction is the trap word, the unit freezes the front of the pipeline,
//   waits for the in-flight instructions to retire, then reads a fixed window of
//   DMEM words and streams each one out on a valid/ready port.
//   Ports:
//     clock        - system clock, rising edge
//     reset        - asynchronous active-low reset
//     instruction  - instruction currently in decode
//     instr_valid  - decode holds a real (non-bubble, non-stalled) instruction
//     halt         - freezes PC/IF/ID and hands the DMEM port to this unit
//     done         - dump complete, sticky until reset
//     dif          - DMEM read port and dump stream port (trap_dump_if.master)
//   Every output is a flop; each one is loaded from the next-state decode so it
//   lines up with the state it belongs to without any combinational output path.
module trap_dump_unit #(
    parameter logic [31:0] TRAP_WORD    = 32'h44000300,
    parameter logic [31:0] DUMP_BASE    = 32'd8192,
    parameter int unsigned DUMP_WORDS   = 10,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:31] instruction,
    input  logic        instr_valid,
    output logic        halt,
    output logic        done,
    trap_dump_if.master dif
);

    // The drain state always lasts at least one cycle, so with no drain the
    // read still starts the cycle after halt rises.
    localparam logic [31:0] DRAIN_LAST = 32'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    // Wraps when DUMP_WORDS is 0; SEND is never reached in that case.
    localparam logic [31:0] LAST_IDX   = 32'(DUMP_WORDS - 1);
    localparam bit          NO_WORDS   = (DUMP_WORDS == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] idx;
    logic [31:0] idx_nx;
    logic [31:0] drain_cnt;
    logic [31:0] drain_cnt_nx;
    logic [31:0] rd_addr_nx;
    logic        trigger;
    logic        handshake;

    assign trigger   = instr_valid && (instruction == TRAP_WORD);
    assign handshake = (state == S_SEND) && dif.dump_valid && dif.dump_ready;
    // Address arithmetic wraps modulo 2^32.
    assign rd_addr_nx = DUMP_BASE + (idx_nx << 2);

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        drain_cnt_nx = drain_cnt;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_nx     = S_DRAIN;
                    drain_cnt_nx = '0;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nx = NO_WORDS ? S_DONE : S_READ;
                end else begin
                    drain_cnt_nx = drain_cnt + 32'd1;
                end
            end
            S_READ: state_nx = S_WAIT;
            S_WAIT: state_nx = S_SEND;
            S_SEND: begin
                if (handshake) begin
                    if (idx == LAST_IDX) begin
                        state_nx = S_DONE;
                    end else begin
                        idx_nx   = idx + 32'd1;
                        state_nx = S_READ;
                    end
                end
            end
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            idx            <= '0;
            drain_cnt      <= '0;
            halt           <= 1'b0;
            done           <= 1'b0;
            dif.mem_req    <= 1'b0;
            dif.mem_addr   <= '0;
            dif.dump_valid <= 1'b0;
            dif.dump_addr  <= '0;
            dif.dump_data  <= '0;
        end else begin
            state          <= state_nx;
            idx            <= idx_nx;
            drain_cnt      <= drain_cnt_nx;
            halt           <= (state_nx != S_IDLE);
            done           <= (state_nx == S_DONE);
            dif.mem_req    <= (state_nx == S_READ);
            dif.dump_valid <= (state_nx == S_SEND);
            if (state_nx == S_READ) begin
                dif.mem_addr <= rd_addr_nx;
            end
            // mem_addr still holds the address issued in READ while the word returns.
            if (state == S_WAIT) begin
                dif.dump_data <= dif.mem_rdata;
                dif.dump_addr <= dif.mem_addr;
            end
        end
    end

endmodule

// File: tb/tb_trap_dump_unit.sv
// tb_trap_dump_unit
//   Bench for trap_dump_unit: a default-parameter instance plus two boundary
//   instances (no drain with one word; zero words). A small DMEM model serves
//   reads one cycle after mem_req; the expected stream is built from the dump
//   window rules (word k at DUMP_BASE+4k carries DMEM[k]).
module tb_trap_dump_unit;

    localparam logic [31:0] TRAP = 32'h44000300;
    localparam logic [31:0] BASE = 32'd8192;
    localparam int          NW   = 10;

    logic        clock;
    logic        reset;
    logic [0:31] instruction;
    logic        instr_valid;
    logic        halt, done, halt_b, done_b, halt_c, done_c;

    trap_dump_if m_if ();
    trap_dump_if b_if ();
    trap_dump_if c_if ();

    trap_dump_unit u_dut (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .halt(halt), .done(done), .dif(m_if)
    );

    trap_dump_unit #(.DRAIN_CYCLES(0), .DUMP_WORDS(1)) u_dut_b (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .halt(halt_b), .done(done_b), .dif(b_if)
    );

    trap_dump_unit #(.DUMP_WORDS(0)) u_dut_c (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .halt(halt_c), .done(done_c), .dif(c_if)
    );

    logic [31:0] dm [0:15];
    int n_checks = 0;
    int n_errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return dm[off[5:2]];
    endfunction

    always @(posedge clock) begin
        m_if.mem_rdata <= m_if.mem_req ? mem_word(m_if.mem_addr) : 32'h0;
        b_if.mem_rdata <= b_if.mem_req ? mem_word(b_if.mem_addr) : 32'h0;
        c_if.mem_rdata <= c_if.mem_req ? mem_word(c_if.mem_addr) : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_halt"}, 32'(halt), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_mem_req"}, 32'(m_if.mem_req), 0);
        chk({tag, "_mem_addr"}, m_if.mem_addr, 0);
        chk({tag, "_dump_valid"}, 32'(m_if.dump_valid), 0);
        chk({tag, "_dump_addr"}, m_if.dump_addr, 0);
        chk({tag, "_dump_data"}, m_if.dump_data, 0);
    endtask

    task automatic randomize_mem();
        for (int k = 0; k < 16; k++) dm[k] = $urandom;
    endtask

    // Presents the trap word for one edge from IDLE; halt must rise right after.
    task automatic trigger();
        instruction = TRAP;
        instr_valid = 1'b1;
        chk("pre_trig_halt", 32'(halt), 0);
        tick();
        instr_valid = 1'b0;
        instruction = $urandom;
        chk("halt_rise", 32'(halt), 1);
    endtask

    // Drives dump_ready (0: always high, 1: toggles every 2 cycles, 2: random)
    // and scores every read and handshake of the main instance. Cycle 0 is the
    // first cycle with halt high. Stops at done, after stop_after handshakes
    // (when nonzero) or when the cycle budget runs out.
    task automatic run_dump(input int mode, input int stop_after, output int hs, output int first_req);
        int          reads;
        int          last_hs;
        bit          stall;
        bit          r;
        logic [31:0] pa, pd;
        reads = 0; last_hs = -1; stall = 0; pa = '0; pd = '0;
        hs = 0; first_req = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done) break;
            chk("halt_held", 32'(halt), 1);
            if (stall) begin
                chk("stall_valid", 32'(m_if.dump_valid), 1);
                chk("stall_addr", m_if.dump_addr, pa);
                chk("stall_data", m_if.dump_data, pd);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = ((cyc / 2) % 2) == 1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            m_if.dump_ready = r;
            if (m_if.mem_req) begin
                if (first_req < 0) first_req = cyc;
                reads++;
                chk("read_count", 32'(reads), 32'(hs + 1));
                chk("mem_addr", m_if.mem_addr, BASE + 32'(4 * hs));
            end
            if (m_if.dump_valid && r) begin
                chk("dump_addr", m_if.dump_addr, BASE + 32'(4 * hs));
                chk("dump_data", m_if.dump_data, dm[hs]);
                if (mode == 0 && last_hs >= 0) chk("word_period", 32'(cyc - last_hs), 3);
                last_hs = cyc;
                hs++;
            end
            stall = m_if.dump_valid && !r;
            pa = m_if.dump_addr;
            pd = m_if.dump_data;
            tick();
            if (stop_after > 0 && hs == stop_after) break;
        end
    endtask

    task automatic reset_pulse();
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, fr;
        int b_first_req, b_reads, b_hs, b_done_cyc, c_reads, c_done_cyc;
        logic [31:0] w;

        reset = 1'b1;
        instruction = '0;
        instr_valid = 1'b0;
        m_if.dump_ready = 1'b0;
        b_if.dump_ready = 1'b1;
        c_if.dump_ready = 1'b1;
        for (int k = 0; k < 16; k++) dm[k] = 32'(k * 3 + 1);

        #3 reset = 1'b0;
        tick();
        tick();
        check_zero_outputs("in_reset");
        reset = 1'b1;
        #1;
        check_zero_outputs("rst_release");
        tick();

        // Non-trigger cases.
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin
                instruction = TRAP;
                instr_valid = 1'b0;
            end else if (i < 6) begin
                instruction = 32'h44000301;
                instr_valid = 1'b1;
            end else begin
                w = $urandom;
                if (w == TRAP) w = w ^ 32'h1;
                instruction = w;
                instr_valid = 1'b1;
            end
            tick();
            chk("nontrig_halt", 32'(halt), 0);
            chk("nontrig_mem_req", 32'(m_if.mem_req), 0);
            chk("nontrig_dump_valid", 32'(m_if.dump_valid), 0);
        end
        instr_valid = 1'b0;
        tick();

        // Basic dump, data k*3+1, ready held high.
        trigger();
        run_dump(0, 0, hs, fr);
        chk("basic_first_req", 32'(fr), 3);
        chk("basic_words", 32'(hs), NW);
        chk("basic_done", 32'(done), 1);

        // Trap word again after done.
        instruction = TRAP;
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("retrig_done", 32'(done), 1);
            chk("retrig_halt", 32'(halt), 1);
            chk("retrig_mem_req", 32'(m_if.mem_req), 0);
            chk("retrig_dump_valid", 32'(m_if.dump_valid), 0);
        end
        instr_valid = 1'b0;

        // Backpressure with dump_ready toggling every 2 cycles.
        reset_pulse();
        randomize_mem();
        tick();
        trigger();
        run_dump(1, 0, hs, fr);
        chk("bp_words", 32'(hs), NW);
        chk("bp_done", 32'(done), 1);

        // Reset mid-dump after the 4th handshake, then a full dump again.
        reset_pulse();
        randomize_mem();
        tick();
        trigger();
        run_dump(2, 4, hs, fr);
        chk("mid_hs_count", 32'(hs), 4);
        #2 reset = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        tick();
        check_zero_outputs("rst_hold");
        reset = 1'b1;
        #1;
        check_zero_outputs("rst_release2");
        for (int i = 0; i < 5; i++) begin
            m_if.dump_ready = 1'b1;
            tick();
            chk("post_rst_valid", 32'(m_if.dump_valid), 0);
            chk("post_rst_mem_req", 32'(m_if.mem_req), 0);
            chk("post_rst_halt", 32'(halt), 0);
        end
        trigger();
        run_dump(2, 0, hs, fr);
        chk("restart_first_req", 32'(fr), 3);
        chk("restart_words", 32'(hs), NW);
        chk("restart_done", 32'(done), 1);

        // Boundary instances: no drain with one word, and zero words.
        reset_pulse();
        randomize_mem();
        tick();
        trigger();
        chk("b_halt_rise", 32'(halt_b), 1);
        chk("c_halt_rise", 32'(halt_c), 1);
        b_first_req = -1; b_reads = 0; b_hs = 0; b_done_cyc = -1;
        c_reads = 0; c_done_cyc = -1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (b_if.mem_req) begin
                if (b_first_req < 0) b_first_req = cyc;
                b_reads++;
                chk("b_mem_addr", b_if.mem_addr, BASE);
            end
            if (b_if.dump_valid) begin
                b_hs++;
                chk("b_dump_addr", b_if.dump_addr, BASE);
                chk("b_dump_data", b_if.dump_data, dm[0]);
            end
            if (done_b && b_done_cyc < 0) b_done_cyc = cyc;
            if (c_if.mem_req) c_reads++;
            if (c_if.dump_valid) c_reads++;
            if (done_c && c_done_cyc < 0) c_done_cyc = cyc;
            tick();
        end
        chk("b_first_req", 32'(b_first_req), 1);
        chk("b_reads", 32'(b_reads), 1);
        chk("b_words", 32'(b_hs), 1);
        chk("b_done_cyc", 32'(b_done_cyc), 4);
        chk("b_halt_end", 32'(halt_b), 1);
        chk("c_reads", 32'(c_reads), 0);
        chk("c_done_cyc", 32'(c_done_cyc), 3);
        chk("c_halt_end", 32'(halt_c), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
